// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one memory request at a time and buffers
// returned {pc, instruction} pairs in a small FIFO toward decode.
module inst_fetch #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        flush,
    output logic        if_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t          state, state_n;
    logic            mem_req_n;
    logic [31:0]     mem_addr_n;
    logic [31:0]     req_pc, req_pc_n;

    logic [31:0]     fifo_pc   [DEPTH];
    logic [31:0]     fifo_inst [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count, count_nxt;
    logic            push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign id_valid = (count != '0);
    assign id_pc    = fifo_pc[rptr];
    assign id_inst  = fifo_inst[rptr];
    assign push     = (state == WAIT) && mem_rvalid && !flush;
    assign pop      = id_valid && id_ready;
    assign if_stall = (state != IDLE) || (count == FULL) || flush;

    // Occupancy after this cycle's push/pop, used by the back-to-back launch check
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Fetch FSM state and registered memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            req_pc   <= '0;
        end else begin
            state    <= state_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            req_pc   <= req_pc_n;
        end
    end

    // Next-state and next request values; flush overrides launch
    always_comb begin
        state_n    = state;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        req_pc_n   = req_pc;
        case (state)
            IDLE: begin
                if (ce && !flush && (count < FULL)) begin
                    state_n    = REQ;
                    mem_req_n  = 1'b1;
                    mem_addr_n = pc;
                    req_pc_n   = pc;
                end
            end
            REQ: begin
                if (flush) begin
                    mem_req_n = 1'b0;
                    state_n   = mem_gnt ? DRAIN : IDLE;
                end else if (mem_gnt) begin
                    mem_req_n = 1'b0;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    if (ce && (count_nxt < FULL)) begin
                        state_n    = REQ;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        req_pc_n   = pc;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DRAIN: begin
                // The returning beat closes the abandoned transaction even if
                // another flush coincides with it; otherwise DRAIN would never exit.
                if (mem_rvalid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output FIFO storage, pointers and occupancy; flush empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_pc[wptr]   <= req_pc;
                fifo_inst[wptr] <= mem_rdata;
                wptr            <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch (DEPTH=2); memory responses are driven by
// hand and a monitor checks every consumed FIFO entry against a scoreboard.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        if_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];

    inst_fetch #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .flush      (flush),
        .if_stall   (if_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_ready   (id_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one fetch, grant immediately, return data the cycle after grant
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; pc = a; mem_gnt = 1'b1;
        step();
        check("fetch_req", {31'd0, mem_req}, 32'd1);
        check("fetch_addr", mem_addr, a);
        ce = 1'b0;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
        exp_q.push_back({a, d});
        step();
        mem_rvalid = 1'b0;
    endtask

    // Monitor: every entry consumed by decode must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got pc 0x%08h inst 0x%08h, expected no entry", id_pc, id_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_pc", id_pc, e[63:32]);
                check("pop_inst", id_inst, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b0; pc = '0; ce = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_stall", {31'd0, if_stall}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        #9 rst = 1'b0;
        step();
        check("post_rst_idle", {31'd0, mem_req}, 32'd0);

        // Basic fetch with 3-cycle latency
        id_ready = 1'b1; ce = 1'b1; pc = 32'h0; mem_gnt = 1'b1;
        step();
        check("basic_req", {31'd0, mem_req}, 32'd1);
        check("basic_addr", mem_addr, 32'h0);
        ce = 1'b0;
        step();
        check("basic_wait_req", {31'd0, mem_req}, 32'd0);
        check("basic_wait_stall", {31'd0, if_stall}, 32'd1);
        check("basic_not_yet", {31'd0, id_valid}, 32'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        exp_q.push_back({32'h0, 32'h0000_0013});
        step();
        mem_rvalid = 1'b0;
        check("basic_valid", {31'd0, id_valid}, 32'd1);
        check("basic_pc", id_pc, 32'h0);
        check("basic_inst", id_inst, 32'h0000_0013);
        step();
        check("basic_empty", {31'd0, id_valid}, 32'd0);

        // Backpressure: fill both entries back to back, then drain in order
        id_ready = 1'b0; ce = 1'b1; pc = 32'h0; mem_gnt = 1'b1;
        step();
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001; pc = 32'h4;
        exp_q.push_back({32'h0, 32'hAAAA_0001});
        step();
        check("bp_relaunch_req", {31'd0, mem_req}, 32'd1);
        check("bp_relaunch_addr", mem_addr, 32'h4);
        mem_rvalid = 1'b0;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBBBB_0002;
        exp_q.push_back({32'h4, 32'hBBBB_0002});
        step();
        mem_rvalid = 1'b0;
        check("bp_full_stall", {31'd0, if_stall}, 32'd1);
        check("bp_full_req", {31'd0, mem_req}, 32'd0);
        check("bp_full_valid", {31'd0, id_valid}, 32'd1);
        step();
        check("bp_no_launch", {31'd0, mem_req}, 32'd0);
        check("bp_still_stall", {31'd0, if_stall}, 32'd1);
        ce = 1'b0; mem_gnt = 1'b0; id_ready = 1'b1;
        step();
        step();
        check("bp_drained", {31'd0, id_valid}, 32'd0);

        // Grant delayed 3 cycles; stray rvalid while in REQ is ignored
        ce = 1'b1; pc = 32'h8; mem_gnt = 1'b0;
        step();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("gd_req", {31'd0, mem_req}, 32'd1);
            check("gd_addr", mem_addr, 32'h8);
            check("gd_no_valid", {31'd0, id_valid}, 32'd0);
            mem_rvalid = (i == 1);
            mem_rdata = 32'hBAD0_BAD0;
            step();
        end
        mem_rvalid = 1'b0;
        check("gd_req_held", {31'd0, mem_req}, 32'd1);
        check("gd_addr_held", mem_addr, 32'h8);
        mem_gnt = 1'b1;
        step();
        check("gd_wait_req", {31'd0, mem_req}, 32'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCCCC_0003;
        exp_q.push_back({32'h8, 32'hCCCC_0003});
        step();
        mem_rvalid = 1'b0;
        step();
        check("gd_empty", {31'd0, id_valid}, 32'd0);

        // Flush in WAIT before the beat; the late beat is dropped
        ce = 1'b1; pc = 32'hC; mem_gnt = 1'b1;
        step();
        ce = 1'b0;
        step();
        mem_gnt = 1'b0; flush = 1'b1;
        #1 check("fw_stall", {31'd0, if_stall}, 32'd1);
        step();
        flush = 1'b0;
        check("fw_drain_stall", {31'd0, if_stall}, 32'd1);
        step();
        check("fw_drain_hold", {31'd0, if_stall}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        check("fw_no_push", {31'd0, id_valid}, 32'd0);
        check("fw_idle", {31'd0, if_stall}, 32'd0);

        // Flush empties a buffered entry and blocks a same-cycle launch
        id_ready = 1'b0;
        fetch_one(32'h30, 32'h1111_1111);
        check("fb_buffered", {31'd0, id_valid}, 32'd1);
        flush = 1'b1; ce = 1'b1; pc = 32'h40;
        exp_q.delete();
        step();
        flush = 1'b0; ce = 1'b0;
        check("fb_cleared", {31'd0, id_valid}, 32'd0);
        check("fb_no_launch", {31'd0, mem_req}, 32'd0);

        // Simultaneous push and pop keeps one entry, head moves on
        fetch_one(32'h10, 32'hDDDD_0004);
        ce = 1'b1; pc = 32'h14; mem_gnt = 1'b1;
        step();
        ce = 1'b0;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hEEEE_0005; id_ready = 1'b1;
        exp_q.push_back({32'h14, 32'hEEEE_0005});
        step();
        mem_rvalid = 1'b0;
        check("pp_valid", {31'd0, id_valid}, 32'd1);
        check("pp_head_pc", id_pc, 32'h14);
        check("pp_head_inst", id_inst, 32'hEEEE_0005);
        step();
        check("pp_empty", {31'd0, id_valid}, 32'd0);

        // Asynchronous reset in the middle of REQ
        id_ready = 1'b0;
        fetch_one(32'h18, 32'hFFFF_0006);
        ce = 1'b1; pc = 32'h20;
        step();
        check("ar_req_before", {31'd0, mem_req}, 32'd1);
        check("ar_valid_before", {31'd0, id_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_mem_req", {31'd0, mem_req}, 32'd0);
        check("ar_id_valid", {31'd0, id_valid}, 32'd0);
        check("ar_mem_addr", mem_addr, 32'd0);
        check("ar_id_pc", id_pc, 32'd0);
        exp_q.delete();
        ce = 1'b0;
        #2 rst = 1'b0;
        step();
        check("ar_no_drain", {31'd0, if_stall}, 32'd0);
        check("ar_idle_req", {31'd0, mem_req}, 32'd0);

        // Normal operation resumes after reset
        id_ready = 1'b1;
        fetch_one(32'h24, 32'h0010_0093);
        check("rec_valid", {31'd0, id_valid}, 32'd1);
        step();
        check("rec_empty", {31'd0, id_valid}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
